// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed seven-segment scanner.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Sized for the widest supported display; unused upper digits stay zero.
    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] data;
        logic [MAX_DIGITS-1:0]   dp;
        logic [MAX_DIGITS-1:0]   blink;
        logic                    lz_en;
    } disp_rec_t;

    // Active-low a..g, bit 6 = a, bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low a..g segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] a_to_g
);

    always_comb begin
        a_to_g = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous load,
// leading-zero blanking, per-digit decimal point and per-digit blink.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NDIGITS      = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [4*NDIGITS-1:0]   data_in,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic [NDIGITS-1:0]     blink_in,
    input  logic                   lz_en,
    input  logic                   load,
    output logic                   frame_tick,
    output logic [7:0]             segment,
    output logic [NDIGITS-1:0]     an
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]      pre_q;
    logic [IW-1:0]      idx_q;
    logic [BW-1:0]      blink_cnt_q;
    logic               blink_phase_q;
    disp_rec_t          active_q, pending_q;
    logic               pending_flag_q;
    logic [7:0]         seg_q;
    logic [NDIGITS-1:0] an_q;

    logic               pre_last, boundary;
    disp_rec_t          in_rec;
    logic [3:0]         nibble;
    logic               dp_sel, blink_sel, lz_blank, blank;
    logic [6:0]         dec_seg;
    logic [7:0]         seg_d;
    logic [NDIGITS-1:0] an_d;
    logic [31:0]        idx_wide;

    assign pre_last   = (pre_q == PRE_LAST);
    assign boundary   = pre_last && (idx_q == IDX_LAST);
    assign frame_tick = boundary;
    assign idx_wide   = 32'(idx_q);

    always_comb begin
        in_rec                      = '0;
        in_rec.data[4*NDIGITS-1:0]  = data_in;
        in_rec.dp[NDIGITS-1:0]      = dp_in;
        in_rec.blink[NDIGITS-1:0]   = blink_in;
        in_rec.lz_en                = lz_en;
    end

    // Prescaler, digit index and blink timebase.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre_q         <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            if (pre_last) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            if (boundary) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // Active only changes on the frame boundary so a frame never mixes two loads.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_flag_q <= 1'b0;
        end else begin
            if (load) begin
                pending_q <= in_rec;
            end
            if (boundary) begin
                if (load) begin
                    active_q <= in_rec;
                end else if (pending_flag_q) begin
                    active_q <= pending_q;
                end
                pending_flag_q <= 1'b0;
            end else if (load) begin
                pending_flag_q <= 1'b1;
            end
        end
    end

    // Walk from the most significant digit down so upper_zero covers digits k..top.
    always_comb begin
        logic upper_zero;
        nibble     = 4'h0;
        dp_sel     = 1'b0;
        blink_sel  = 1'b0;
        lz_blank   = 1'b0;
        upper_zero = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (active_q.data[4*k +: 4] == 4'h0);
            if (idx_wide == 32'(k)) begin
                nibble    = active_q.data[4*k +: 4];
                dp_sel    = active_q.dp[k];
                blink_sel = active_q.blink[k];
                lz_blank  = active_q.lz_en & upper_zero & (k != 0);
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble (nibble),
        .a_to_g (dec_seg)
    );

    always_comb begin
        blank = lz_blank | (blink_phase_q & blink_sel);
        seg_d = blank ? {1'b1, SEG_BLANK} : {~dp_sel, dec_seg};
        an_d  = ~(NDIGITS'(1) << idx_q);
    end

    // Segment and anode share one register stage so they switch on the same edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign segment = seg_q;
    assign an      = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a frame-level model queues expected digit slots.
module tb_seg_scan_display;

    localparam int unsigned N     = 4;
    localparam int unsigned RD    = 4;
    localparam int unsigned BF    = 2;
    localparam int          FRAME = N * RD;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        lz;
    } rec_t;

    logic           clk = 1'b0;
    logic           clr;
    logic [4*N-1:0] data_in;
    logic [N-1:0]   dp_in, blink_in;
    logic           lz_en, load;
    logic           frame_tick;
    logic [7:0]     segment;
    logic [N-1:0]   an;

    seg_scan_display #(
        .NDIGITS      (N),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blink_in   (blink_in),
        .lz_en      (lz_en),
        .load       (load),
        .frame_tick (frame_tick),
        .segment    (segment),
        .an         (an)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [11:0] exp_q[$];
    int          t;
    int          frames;
    bit          in_reset = 1'b1;
    bit          done = 1'b0;
    bit          exp_tick = 1'b0;
    rec_t        last_load, frame_rec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, req, t);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    // Expected {an, segment} for digit d under the frame content currently in force.
    function automatic logic [11:0] slot_expect(input int d);
        bit         phase, blank;
        logic [7:0] seg;
        logic [3:0] an_e;
        phase = ((frames / BF) % 2) == 1;
        blank = (phase && frame_rec.blink[d])
             || (frame_rec.lz && d != 0 && (frame_rec.data >> (4 * d)) == 16'h0);
        seg   = blank ? 8'hFF : {~frame_rec.dp[d], hex7(4'(frame_rec.data >> (4 * d)))};
        an_e  = ~(4'b0001 << d);
        return {an_e, seg};
    endfunction

    function automatic rec_t mk(input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] bl, input logic lz);
        rec_t r;
        r.data = d; r.dp = dp; r.blink = bl; r.lz = lz;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        for (int k = 0; k < N; k++)
            r.data[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        r.dp    = 4'($urandom);
        r.blink = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        r.lz    = 1'($urandom);
        return r;
    endfunction

    // One clock cycle of the model; t is the cycle index since reset release.
    task automatic model_cycle(input bit do_load, input rec_t r);
        if (t % RD == 0) exp_q.push_back(slot_expect((t / RD) % N));
        exp_tick = (t % FRAME == FRAME - 1);
        load     = do_load;
        if (do_load) begin
            data_in   = r.data;
            dp_in     = r.dp;
            blink_in  = r.blink;
            lz_en     = r.lz;
            last_load = r;
        end
        if (exp_tick) begin
            frame_rec = last_load;
            frames++;
        end
    endtask

    task automatic release_reset();
        clr       = 1'b1;
        t         = 0;
        frames    = 0;
        last_load = '0;
        frame_rec = '0;
        exp_q.delete();
        model_cycle(1'b0, '0);
        in_reset  = 1'b0;
    endtask

    initial begin
        rec_t r;
        bit   ld;
        clr = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; blink_in = '0; lz_en = 1'b0;
        #7;
        release_reset();
        for (int c = 1; c <= 218; c++) begin
            @(posedge clk); #1;
            t++;
            ld = 1'b1;
            case (t)
                15:      r = mk(16'h1234, 4'b0000, 4'b0000, 1'b0);
                37:      r = mk(16'hABCD, 4'b0000, 4'b0000, 1'b0);
                63:      r = mk(16'h0050, 4'b0000, 4'b0000, 1'b1);
                90:      r = mk(16'h0000, 4'b0000, 4'b0000, 1'b1);
                120:     r = mk(16'h1234, 4'b0010, 4'b0001, 1'b0);
                207:     r = mk(16'h5678, 4'b1001, 4'b0000, 1'b0);
                default: begin ld = 1'b0; r = '0; end
            endcase
            model_cycle(ld, r);
        end
        // Reset mid-digit: outputs must drop before the next clock edge.
        #1;
        in_reset = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        #1;
        check("reset_segment", segment, 8'hFF);
        check("reset_an", an, 4'hF);
        check("reset_tick", frame_tick, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("reset_hold_segment", segment, 8'hFF);
        check("reset_hold_an", an, 4'hF);
        release_reset();
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            t++;
            ld = ($urandom_range(0, 9) == 0) || (t % FRAME == FRAME - 1 && $urandom_range(0, 2) == 0);
            r  = rand_rec();
            model_cycle(ld, r);
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            t++;
            model_cycle(1'b0, '0);
        end
        done = 1'b1;
        @(negedge clk); #1;
        check("queue_drained", (exp_q.size() <= 1) ? 32'd1 : 32'd0, 32'd1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Monitor: every new anode pattern is one digit slot presented by the DUT.
    initial begin
        logic [N-1:0] prev_an;
        logic [11:0]  e;
        prev_an = '1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (in_reset) begin
                prev_an = '1;
                continue;
            end
            check("frame_tick", frame_tick, exp_tick);
            if (an !== prev_an) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL slot_unexpected: got an=%0h, expected no new slot (t=%0d)", an, t);
                end else begin
                    e = exp_q.pop_front();
                    check("anode", an, e[11:8]);
                    check("segment", segment, e[7:0]);
                end
                prev_an = an;
            end
        end
    end

endmodule
